// File: rtl/mem_wait_ctrl.sv
// Word-serial memory controller: latches one request, inserts LATENCY wait states,
// accesses a synchronous single-port RAM and pulses a one-cycle ack. Optional MEM_RANGE_CHECK_EN.
module mem_wait_ctrl #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          LATENCY    = 4,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_cs_i,
  input  logic                  mem_we_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_data_i,
  output logic [31:0]           mem_data_o,
  output logic                  mem_ack_o,
  output logic                  busy_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_din_o,
  input  logic [31:0]           ram_dout_i,
  output logic                  err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ACCESS, S_READ, S_ACK, S_GAP
  } state_t;

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  state_t                r_state, w_next;
  logic [3:0]            r_wcnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_data;
  logic [31:0]           r_rdata;
  logic                  r_oor;
  logic                  w_oor;
  logic                  w_unused;

  // Byte-lane bits never select a word; upper bits matter only to the range check.
  assign w_unused = ^{mem_addr_i[1:0], mem_addr_i[31:ADDR_WIDTH+2]};

`ifdef MEM_RANGE_CHECK_EN
  assign w_oor = |mem_addr_i[31:ADDR_WIDTH+2];
`else
  assign w_oor = 1'b0;
`endif

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_oor   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (mem_cs_i) begin
            r_addr <= mem_addr_i[ADDR_WIDTH+1:2];
            r_we   <= mem_we_i;
            r_data <= mem_data_i;
            r_oor  <= w_oor;
            r_wcnt <= LAT4;
          end
        end
        S_WAIT:  r_wcnt  <= r_wcnt - 4'd1;
        S_READ:  r_rdata <= r_oor ? ERR_DATA : ram_dout_i;
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned and a latch cannot be inferred.
  always_comb begin
    w_next   = r_state;
    ram_en_o = 1'b0;
    ram_we_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_cs_i) w_next = (LAT4 != 4'd0) ? S_WAIT : S_ACCESS;
      end
      S_WAIT: begin
        if (r_wcnt <= 4'd1) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        ram_en_o = ~r_oor;
        ram_we_o = r_we & ~r_oor;
        w_next   = r_we ? S_ACK : S_READ;
      end
      S_READ:  w_next = S_ACK;
      S_ACK:   w_next = S_GAP;
      S_GAP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign mem_data_o = r_rdata;
  assign mem_ack_o  = (r_state == S_ACK);
  assign busy_o     = (r_state != S_IDLE);
  assign ram_addr_o = r_addr;
  assign ram_din_o  = r_data;

`ifdef MEM_RANGE_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_err <= 1'b0;
    else if (r_state == S_ACCESS && r_oor)   r_err <= 1'b1;
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Scoreboard bench for mem_wait_ctrl: a LATENCY=4 instance with a RAM model and
// a LATENCY=0 instance; expected acks are queued at request time and popped on ack.
module tb_mem_wait_ctrl;

  localparam int AW  = 10;
  localparam int LAT = 4;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } ack_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          cs = 1'b0, we = 1'b0;
  logic [31:0]   addr = '0, wdata = '0;
  logic [31:0]   data_o, ram_din, ram_dout;
  logic          ack, busy, ram_en, ram_we, err;
  logic [AW-1:0] ram_addr;

  logic          cs0 = 1'b0;
  logic [31:0]   addr0 = '0;
  logic [31:0]   data_o0, ram_din0, ram_dout0;
  logic          ack0, busy0, ram_en0, ram_we0, err0;
  logic [AW-1:0] ram_addr0;

  mem_wait_ctrl #(.ADDR_WIDTH(AW), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .mem_cs_i(cs), .mem_we_i(we), .mem_addr_i(addr),
    .mem_data_i(wdata), .mem_data_o(data_o), .mem_ack_o(ack), .busy_o(busy),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_din_o(ram_din), .ram_dout_i(ram_dout), .err_o(err)
  );

  mem_wait_ctrl #(.ADDR_WIDTH(AW), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_cs_i(cs0), .mem_we_i(1'b0), .mem_addr_i(addr0),
    .mem_data_i(32'h0), .mem_data_o(data_o0), .mem_ack_o(ack0), .busy_o(busy0),
    .ram_en_o(ram_en0), .ram_we_o(ram_we0), .ram_addr_o(ram_addr0),
    .ram_din_o(ram_din0), .ram_dout_i(ram_dout0), .err_o(err0)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          en_cnt   = 0;
  int          we_cnt   = 0;
  int          en0_cnt  = 0;
  int          en0_cyc  = -1;
  logic        ram_init = 1'b1;
  logic [31:0] ram     [0:(1<<AW)-1];
  logic [31:0] exp_mem [0:(1<<AW)-1];
  exp_t        exp_q[$];
  exp_t        exp0_q[$];
  ack_t        ack_q[$];
  ack_t        ack0_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: read data appears the cycle after the enable.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= 32'hA500_0000 | 32'(i);
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_din;
      ram_dout <= ram[ram_addr];
    end
  end

  always @(posedge clk) if (ram_en0) ram_dout0 <= {ram_addr0, 22'h2A5A5A};

  always @(negedge clk) begin
    if (ack)  ack_q.push_back('{cyc: cyc, data: data_o});
    if (ack0) ack0_q.push_back('{cyc: cyc, data: data_o0});
    if (ram_en) en_cnt <= en_cnt + 1;
    if (ram_en && ram_we) we_cnt <= we_cnt + 1;
    if (ram_en0) begin
      en0_cnt <= en0_cnt + 1;
      en0_cyc <= cyc;
    end
  end

  // Waits for the DUT to be idle, presents a request and queues its expected ack.
  task automatic drive_req(input bit w, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    cs = 1'b1; we = w; addr = a; wdata = d;
    exp_q.push_back('{rd: !w, data: w ? 32'h0 : exp_mem[a[AW+1:2]],
                      due: cyc + 1 + LAT + (w ? 1 : 2)});
    if (w) exp_mem[a[AW+1:2]] = d;
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (ack_q.size() > 0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    int en_before;
    rst = 1'b0; ram_init = 1'b1;
    repeat (3) @(negedge clk);
    ram_init = 1'b0;
    n_checks++;
    if ({data_o, ack, busy, ram_en, ram_we, ram_addr, ram_din, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h ack=%b busy=%b en=%b err=%b required all 0",
               data_o, ack, busy, ram_en, err);
    end
    rst = 1'b1;
    @(negedge clk); cs = 1'b1; we = 1'b1; addr = 32'h80; wdata = 32'hCAFE_F00D;
    @(negedge clk); cs = 1'b0;
    @(negedge clk); #1;
    en_before = en_cnt;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_in_wait: got %b required 1", busy);
    end
    rst = 1'b0; #1;
    n_checks++;
    if ({data_o, ack, busy, ram_en, ram_we, ram_addr, ram_din, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: got busy=%b addr=%h din=%h required all 0",
               busy, ram_addr, ram_din);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk); #1;
    n_checks++;
    if (en_cnt !== en_before || ack_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dropped_write: got en_pulses=%0d acks=%0d busy=%b required 0 0 0",
               en_cnt - en_before, ack_q.size(), busy);
    end
    n_checks++;
    if (ram[32] !== exp_mem[32]) begin
      n_fail++; $display("FAIL ram_untouched: got %h required %h", ram[32], exp_mem[32]);
    end
  endtask

  task automatic test_write_read();
    int   en_b, we_b;
    bit   ok;
    ack_t a;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      #1; en_b = en_cnt; we_b = we_cnt;
      drive_req(k == 0, 32'h40, 32'h1234_5678);
      @(negedge clk); cs = 1'b0;
      wait_ack(ok);
      n_checks++;
      if (!ok) begin
        n_fail++; $display("FAIL wr_rd_ack_timeout: got no ack required ack (k=%0d)", k);
        continue;
      end
      a = ack_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (a.cyc !== e.due) begin
        n_fail++; $display("FAIL wr_rd_ack_edge: got %0d required %0d (k=%0d)", a.cyc, e.due, k);
      end
      if (e.rd) begin
        n_checks++;
        if (a.data !== 32'h1234_5678) begin
          n_fail++; $display("FAIL read_back: got %h required 12345678", a.data);
        end
      end
      n_checks++;
      if (en_cnt - en_b != 1 || we_cnt - we_b != (k == 0 ? 1 : 0)) begin
        n_fail++;
        $display("FAIL wr_rd_en_pulses: got en=%0d we=%0d required 1 %0d",
                 en_cnt - en_b, we_cnt - we_b, k == 0 ? 1 : 0);
      end
    end
  endtask

  task automatic test_latency0();
    exp_t e;
    ack_t a;
    bit   ok = 1'b0;
    int   e0;
    @(negedge clk);
    cs0 = 1'b1; addr0 = 32'h0000_0124; e0 = cyc + 1;
    exp0_q.push_back('{rd: 1'b1, data: {addr0[AW+1:2], 22'h2A5A5A}, due: e0 + 2});
    @(negedge clk); cs0 = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (ack0_q.size() > 0);
    end
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL lat0_ack_timeout: got no ack required ack");
      return;
    end
    a = ack0_q.pop_front(); e = exp0_q.pop_front();
    n_checks++;
    if (a.cyc !== e.due || a.data !== e.data) begin
      n_fail++;
      $display("FAIL lat0_ack: got edge=%0d data=%h required edge=%0d data=%h",
               a.cyc, a.data, e.due, e.data);
    end
    n_checks++;
    if (en0_cyc !== e0 || en0_cnt !== 1) begin
      n_fail++;
      $display("FAIL lat0_no_wait: got en_edge=%0d en_count=%0d required %0d 1",
               en0_cyc, en0_cnt, e0);
    end
  endtask

  task automatic test_back_to_back();
    int   prev = 0;
    bit   ok;
    ack_t a;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b0, 32'(4 * i), 32'h0);
      wait_ack(ok);
      n_checks++;
      if (!ok) begin
        n_fail++; $display("FAIL fill_ack_timeout: got no ack required ack (word %0d)", i);
        break;
      end
      a = ack_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (a.cyc !== e.due || a.data !== e.data) begin
        n_fail++;
        $display("FAIL fill_word%0d: got edge=%0d data=%h required edge=%0d data=%h",
                 i, a.cyc, a.data, e.due, e.data);
      end
      if (i > 0) begin
        n_checks++;
        if (a.cyc - prev != LAT + 5) begin
          n_fail++; $display("FAIL fill_spacing: got %0d required %0d", a.cyc - prev, LAT + 5);
        end
      end
      prev = a.cyc;
    end
    cs = 1'b0;
  endtask

  task automatic test_cs_drop();
    int   en_b;
    bit   ok;
    ack_t a;
    exp_t e;
    repeat (3) @(negedge clk);
    #1; en_b = en_cnt;
    drive_req(1'b0, 32'h10, 32'h0);
    @(negedge clk); cs = 1'b0;
    wait_ack(ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL drop_ack_timeout: got no ack required ack");
      return;
    end
    a = ack_q.pop_front(); e = exp_q.pop_front();
    n_checks++;
    if (a.cyc !== e.due || a.data !== e.data) begin
      n_fail++;
      $display("FAIL drop_ack: got edge=%0d data=%h required edge=%0d data=%h",
               a.cyc, a.data, e.due, e.data);
    end
    repeat (15) @(negedge clk); #1;
    n_checks++;
    if (ack_q.size() != 0 || busy !== 1'b0 || en_cnt - en_b != 1) begin
      n_fail++;
      $display("FAIL drop_single_txn: got extra_acks=%0d busy=%b en=%0d required 0 0 1",
               ack_q.size(), busy, en_cnt - en_b);
    end
  endtask

  task automatic test_range();
    int   en_b;
    bit   ok;
    ack_t a;
    exp_t e;
    bit   chk = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
    chk = 1'b1;
`endif
    #1; en_b = en_cnt;
    drive_req(1'b0, 32'h0001_0000, 32'h0);
    if (chk) exp_q[exp_q.size() - 1].data = 32'hDEAD_BEEF;
    @(negedge clk); cs = 1'b0;
    wait_ack(ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL range_ack_timeout: got no ack required ack");
      return;
    end
    a = ack_q.pop_front(); e = exp_q.pop_front();
    n_checks++;
    if (a.cyc !== e.due || a.data !== e.data) begin
      n_fail++;
      $display("FAIL range_read: got edge=%0d data=%h required edge=%0d data=%h",
               a.cyc, a.data, e.due, e.data);
    end
    repeat (4) @(negedge clk); #1;
    n_checks++;
    if (en_cnt - en_b != (chk ? 0 : 1) || err !== chk) begin
      n_fail++;
      $display("FAIL range_flags: got en=%0d err=%b required %0d %b",
               en_cnt - en_b, err, chk ? 0 : 1, chk);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL range_err_reset: got %b required 0", err);
    end
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) exp_mem[i] = 32'hA500_0000 | 32'(i);
    test_reset();
    test_write_read();
    test_latency0();
    test_back_to_back();
    test_cs_drop();
    test_range();
    n_checks++;
    if (exp_q.size() != 0 || ack_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got pending_exp=%0d pending_ack=%0d required 0 0",
               exp_q.size(), ack_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
